p_encoder_7_3: RTL and testbench
================================

# p_encoder_7_3

Registered 8-input priority encoder: reports the index of the highest-set bit of an 8-bit request vector as a 3-bit code, plus a valid flag. Used wherever a single winner must be selected from a bank of request/interrupt lines. The combinational encode is followed by one output register stage clocked by the system clock.

## Interface
- `IN_W`, default 8, request vector width; must be a power of two, at least 2.
- `OUT_W`, default `$clog2(IN_W)` = 3, encoded index width.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `en`  input  1  capture enable; when low, outputs hold their values.
- `a_in`  input  `IN_W` (8)  request vector; bit 7 has highest priority, bit 0 lowest.
- `a_out`  output  `OUT_W` (3)  index of the highest set bit of `a_in`.
- `valid`  output  1  high when the captured `a_in` had at least one bit set.

## Operation
- Combinational priority search: find the highest `i` such that `a_in[i]=1`. This gives `idx=i` and `any=1`.
- If `a_in` is zero: `idx=0`, `any=0`.
- Lower-order bits are ignored whenever a higher bit is set. Examples:
  - 8'h43 -> 6
  - 8'h2F -> 5
  - 8'h18 -> 4
- Encoding is unsigned binary; there is no one-hot output.
- Register stage: on a clock edge with `en=1`, `a_out<=idx` and `valid<=any`. With `en=0`, both registers hold.
- `a_out` is 0 whenever `valid` is 0. Consumers must qualify `a_out` with `valid`, because index 0 and "no request" share the same `a_out` code.
- X or Z on `a_in` is not required to be handled. The bench drives only known values.

## Timing
- Latency is 1 cycle. `a_in` sampled at edge N appears on `a_out`/`valid` immediately after edge N.
- Throughput is one new vector per cycle. There is no handshake or backpressure.
- Reset:
  - `rst_n` low clears `a_out` to 3'b000 and `valid` to 0 immediately, with no clock needed.
  - Both outputs stay cleared while `rst_n` is low, regardless of `en` and `a_in`.
- First capture is at the first rising edge after `rst_n` deasserts, provided `en=1` at that edge.
- Reset asserted mid-stream discards the registered result. There is no other state.
- `en` and `a_in` changing in the same cycle: the values present at the edge are used.

## Structure
- Shared package `p_encoder_pkg`:
  - `IN_W` and `OUT_W` defaults.
  - Typedefs `req_t` (`logic [IN_W-1:0]`) and `idx_t` (`logic [OUT_W-1:0]`).
- Sub-module `p_encoder_core`:
  - Purely combinational, with parameter `IN_W`.
  - Ports: `a_in` -> `idx`, `any`.
  - Implemented as a loop from LSB to MSB, where later (higher) set bits overwrite earlier ones, so it scales with `IN_W`.
- Top `p_encoder_7_3` instantiates the core and holds only the two output registers plus enable logic.
- Include parameter-legality assertions: `IN_W` is a power of two and `OUT_W == $clog2(IN_W)`.

## Test plan
- Reset: hold `rst_n=0` with `a_in`=8'hFF and `en=1` -> `a_out`=0 and `valid`=0. After release, the next edge gives `a_out`=7 and `valid`=1.
- Single-bit sweep with `en=1`: 8'h80, 8'h08, 8'h04, 8'h02, 8'h01 -> `a_out` = 7, 3, 2, 1, 0 one cycle later, `valid`=1 each time.
- Multi-bit priority: 8'h43, 8'h2F, 8'h18 -> `a_out` = 6, 5, 4.
- Zero input: 8'h00 -> `a_out`=0, `valid`=0. Then 8'h01 -> `a_out`=0, `valid`=1, showing `valid` is what tells the two apart.
- Enable hold: capture 8'h80 (`a_out`=7), then drop `en` and drive 8'h01 for 3 cycles -> `a_out` stays 7. Raise `en` -> 0 after one edge.
- Async reset mid-stream: with `a_out`=5, pulse `rst_n` low between clock edges -> outputs clear immediately, not at the next edge. Exhaustive random check of all 256 inputs against a reference model.

Source files
------------

// File: rtl/p_encoder_pkg.sv
// Shared widths, types and helpers for the registered priority encoder.
package p_encoder_pkg;

    localparam int IN_W_DFLT  = 8;
    localparam int OUT_W_DFLT = $clog2(IN_W_DFLT);

    typedef logic [IN_W_DFLT-1:0]  req_t;
    typedef logic [OUT_W_DFLT-1:0] idx_t;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/p_encoder_core.sv
// Combinational priority search: index of the highest set request bit.
module p_encoder_core
    import p_encoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DFLT,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  a_in,
    output logic [OUT_W-1:0] idx,
    output logic             any
);

    // Scan upward so a higher set bit always overwrites a lower one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (a_in[i]) begin
                idx = OUT_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p_encoder_7_3.sv
// Registered priority encoder: one output stage with capture enable.
module p_encoder_7_3
    import p_encoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DFLT,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  a_in,
    output logic [OUT_W-1:0] a_out,
    output logic             valid
);

    if (!is_pow2(IN_W)) begin : g_bad_in_w
        $error("p_encoder_7_3: IN_W must be a power of two and at least 2");
    end
    if (OUT_W != $clog2(IN_W)) begin : g_bad_out_w
        $error("p_encoder_7_3: OUT_W must equal $clog2(IN_W)");
    end

    logic [OUT_W-1:0] idx;
    logic             any;

    logic [OUT_W-1:0] a_out_d, a_out_q;
    logic             valid_d, valid_q;

    p_encoder_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .a_in (a_in),
        .idx  (idx),
        .any  (any)
    );

    always_comb begin
        a_out_d = a_out_q;
        valid_d = valid_q;
        if (en) begin
            a_out_d = idx;
            valid_d = any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            a_out_q <= a_out_d;
            valid_q <= valid_d;
        end
    end

    assign a_out = a_out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_p_encoder_7_3.sv
// Self-checking bench for p_encoder_7_3: directed table, corner sequences, shuffled sweep.
module tb_p_encoder_7_3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] a_in;
    logic [2:0] a_out;
    logic       valid;

    int n_cmp;
    int n_bad;

    logic [2:0] m_out;
    logic       m_valid;

    typedef struct {
        logic [7:0] a;
        logic       e;
        logic [2:0] exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[14];

    p_encoder_7_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a_in  (a_in),
        .a_out (a_out),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit is floor(log2(v)) for v >= 1.
    function automatic int ref_idx(input int v);
        return (v == 0) ? 0 : $clog2(v + 1) - 1;
    endfunction

    task automatic check(input string name, input logic [2:0] act_out, input logic act_valid,
                         input logic [2:0] exp_out, input logic exp_valid);
        n_cmp++;
        if (act_out !== exp_out || act_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL %s: got a_out=%0d valid=%0b, expected a_out=%0d valid=%0b",
                     name, act_out, act_valid, exp_out, exp_valid);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [7:0] a, input logic e);
        @(negedge clk);
        a_in = a;
        en   = e;
        @(posedge clk);
        #1;
        if (e && rst_n) begin
            m_out   = 3'(ref_idx(int'(a)));
            m_valid = (a != 8'h00);
        end
    endtask

    initial begin
        int       order[256];
        int       tmp;
        int       j;
        logic     e;

        n_cmp   = 0;
        n_bad   = 0;
        m_out   = 3'd0;
        m_valid = 1'b0;

        vecs[0]  = '{8'h80, 1'b1, 3'd7, 1'b1};
        vecs[1]  = '{8'h08, 1'b1, 3'd3, 1'b1};
        vecs[2]  = '{8'h04, 1'b1, 3'd2, 1'b1};
        vecs[3]  = '{8'h02, 1'b1, 3'd1, 1'b1};
        vecs[4]  = '{8'h01, 1'b1, 3'd0, 1'b1};
        vecs[5]  = '{8'h43, 1'b1, 3'd6, 1'b1};
        vecs[6]  = '{8'h2F, 1'b1, 3'd5, 1'b1};
        vecs[7]  = '{8'h18, 1'b1, 3'd4, 1'b1};
        vecs[8]  = '{8'h00, 1'b1, 3'd0, 1'b0};
        vecs[9]  = '{8'h01, 1'b1, 3'd0, 1'b1};
        vecs[10] = '{8'h80, 1'b1, 3'd7, 1'b1};
        vecs[11] = '{8'h01, 1'b0, 3'd7, 1'b1};
        vecs[12] = '{8'h01, 1'b0, 3'd7, 1'b1};
        vecs[13] = '{8'h01, 1'b0, 3'd7, 1'b1};

        rst_n = 1'b0;
        en    = 1'b1;
        a_in  = 8'hFF;
        #3;
        check("reset_async", a_out, valid, 3'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", a_out, valid, 3'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(8'hFF, 1'b1);
        check("first_capture", a_out, valid, 3'd7, 1'b1);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].a, vecs[i].e);
            check($sformatf("table[%0d]", i), a_out, valid, vecs[i].exp_out, vecs[i].exp_valid);
        end
        apply(8'h01, 1'b1);
        check("enable_resume", a_out, valid, 3'd0, 1'b1);

        // Reset pulse between edges must clear without a clock.
        apply(8'h2F, 1'b1);
        check("pre_reset", a_out, valid, 3'd5, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", a_out, valid, 3'd0, 1'b0);
        a_in = 8'hFF;
        en   = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ignores_edge", a_out, valid, 3'd0, 1'b0);
        m_out   = 3'd0;
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Every input value once, shuffled, with occasional enable drops.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            e = ($urandom_range(7, 0) != 0);
            apply(8'(order[i]), e);
            check($sformatf("sweep a=%02h en=%0b", order[i], e), a_out, valid, m_out, m_valid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
